// File: rtl/c1541_head_stepper_if.sv
// Signal bundle between the 1541 drive logic / track buffer and the head stepper.
// The slave modport is the stepper side; the master modport drives it.
interface c1541_head_stepper_if;
    logic       ce;
    logic       mtr;
    logic [1:0] stp;
    logic       act;
    logic       buff_we;
    logic       disk_change;
    logic       save_ack;
    logic [6:0] half_track;
    logic [5:0] track;
    logic       tr00_sense_n;
    logic       settling;
    logic       save_req;
    logic [5:0] save_track;

    modport master (
        output ce, mtr, stp, act, buff_we, disk_change, save_ack,
        input  half_track, track, tr00_sense_n, settling, save_req, save_track
    );

    modport slave (
        input  ce, mtr, stp, act, buff_we, disk_change, save_ack,
        output half_track, track, tr00_sense_n, settling, save_req, save_track
    );
endinterface

// File: rtl/c1541_head_stepper.sv
// 1541 head position decoder with settle timer and dirty-track save request.
// Stepper phases move a clamped half-track; leaving a dirty track or activity stopping requests a write-back.
module c1541_head_stepper #(
    parameter int unsigned START_HT = 36,
    parameter int unsigned MIN_HT   = 1,
    parameter int unsigned MAX_HT   = 80,
    parameter int unsigned SETTLE   = 3000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    c1541_head_stepper_if.slave   bus
);

    localparam int unsigned HT_W  = 7;
    localparam int unsigned TRK_W = 6;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t             r_state;
    logic [1:0]         r_stp;
    logic               r_act;
    logic [HT_W-1:0]    r_ht;
    logic [TRK_W-1:0]   r_track;
    logic               r_tr00_n;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_settling;
    logic               r_dirty;
    logic               r_req;
    logic [TRK_W-1:0]   r_save_trk;
    logic               r_pend;
    logic [TRK_W-1:0]   r_pend_trk;

    logic               w_fwd;
    logic               w_rev;
    logic               w_step;
    logic               w_act_fall;
    logic               w_save_ev;
    logic               w_dirty_ev;
    logic [HT_W-1:0]    w_ht_next;
    logic [CNT_W-1:0]   w_cnt_next;

    // Phase-pair decode, next head position, save event and settle count
    always_comb begin
        w_fwd      = 1'b0;
        w_rev      = 1'b0;
        case ({r_stp, bus.stp})
            4'b00_10, 4'b10_01, 4'b01_11, 4'b11_00: w_fwd = 1'b1;
            4'b00_11, 4'b11_01, 4'b01_10, 4'b10_00: w_rev = 1'b1;
            default: ;
        endcase

        w_step    = bus.mtr & (w_fwd | w_rev);
        w_ht_next = r_ht;
        if (bus.mtr && w_fwd && (r_ht < HT_W'(MAX_HT)))
            w_ht_next = r_ht + HT_W'(1);
        else if (bus.mtr && w_rev && (r_ht > HT_W'(MIN_HT)))
            w_ht_next = r_ht - HT_W'(1);

        w_act_fall = r_act & ~bus.act;
        w_save_ev  = w_step | w_act_fall;
        // A same-tick write belongs to the track being left, so it makes the event dirty
        w_dirty_ev = w_save_ev & (r_dirty | bus.buff_we);

        w_cnt_next = r_cnt;
        if (w_ht_next != r_ht)
            w_cnt_next = CNT_W'(SETTLE);
        else if (r_cnt != '0)
            w_cnt_next = r_cnt - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_stp      <= 2'b00;
            r_act      <= 1'b0;
            r_ht       <= HT_W'(START_HT);
            r_track    <= TRK_W'(START_HT >> 1);
            r_tr00_n   <= ((START_HT >> 1) != 0);
            r_cnt      <= '0;
            r_settling <= 1'b0;
            r_dirty    <= 1'b0;
            r_req      <= 1'b0;
            r_save_trk <= '0;
            r_pend     <= 1'b0;
            r_pend_trk <= '0;
        end else if (bus.ce) begin
            r_stp      <= bus.stp;
            r_act      <= bus.act;
            r_ht       <= w_ht_next;
            r_track    <= r_ht[HT_W-1:1];
            r_tr00_n   <= (r_ht[HT_W-1:1] != '0);
            r_cnt      <= w_cnt_next;
            r_settling <= (w_cnt_next != '0);

            if (w_save_ev || bus.disk_change)
                r_dirty <= 1'b0;
            else if (bus.buff_we)
                r_dirty <= 1'b1;

            // Save request handshake; a dirty event during REQ queues one pending track
            case (r_state)
                S_IDLE: begin
                    if (w_dirty_ev) begin
                        r_req      <= 1'b1;
                        r_save_trk <= r_track;
                        r_state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.save_ack) begin
                        if (r_pend) begin
                            r_save_trk <= r_pend_trk;
                            r_pend     <= w_dirty_ev;
                            if (w_dirty_ev)
                                r_pend_trk <= r_track;
                        end else if (w_dirty_ev) begin
                            r_save_trk <= r_track;
                        end else begin
                            r_req   <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else if (w_dirty_ev) begin
                        r_pend     <= 1'b1;
                        r_pend_trk <= r_track;
                    end
                    if (bus.disk_change)
                        r_pend <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.half_track   = r_ht;
    assign bus.track        = r_track;
    assign bus.tr00_sense_n = r_tr00_n;
    assign bus.settling     = r_settling;
    assign bus.save_req     = r_req;
    assign bus.save_track   = r_save_trk;

endmodule

// File: tb/tb_c1541_head_stepper.sv
// Directed bench for c1541_head_stepper: vector table for stepping/save flow plus
// hand sequences for clamping, settle timing and reset during a save.
module tb_c1541_head_stepper;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_err    = 0;

    c1541_head_stepper_if bus ();

    c1541_head_stepper dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ce;
        logic       mtr;
        logic [1:0] stp;
        logic       act;
        logic       we;
        logic       dc;
        logic       ack;
        int         ht;
        int         trk;
        int         req;
        int         strk;
    } vec_t;

    localparam int NVEC = 33;
    vec_t tbl [NVEC];
    logic [1:0] cur_ph;

    function automatic vec_t mk(input logic ce, input logic mtr, input logic [1:0] stp,
                                input logic act, input logic we, input logic dc, input logic ack,
                                input int ht, input int trk, input int req, input int strk);
        vec_t v;
        v.ce = ce; v.mtr = mtr; v.stp = stp; v.act = act; v.we = we; v.dc = dc; v.ack = ack;
        v.ht = ht; v.trk = trk; v.req = req; v.strk = strk;
        return v;
    endfunction

    function automatic logic [1:0] fwd_ph(input logic [1:0] p);
        case (p)
            2'd0: return 2'd2;
            2'd2: return 2'd1;
            2'd1: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] rev_ph(input logic [1:0] p);
        case (p)
            2'd0: return 2'd3;
            2'd3: return 2'd1;
            2'd1: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ce = 1'b1; bus.buff_we = 1'b0; bus.disk_change = 1'b0; bus.save_ack = 1'b0;
    endtask

    initial begin
        bus.ce = 1'b0; bus.mtr = 1'b0; bus.stp = 2'd0; bus.act = 1'b0;
        bus.buff_we = 1'b0; bus.disk_change = 1'b0; bus.save_ack = 1'b0;

        //            ce mtr stp act we dc ack   ht trk req strk
        tbl[0]  = mk(1, 1, 0, 0, 0, 0, 0,  36, 18, 0,  0);
        tbl[1]  = mk(1, 1, 2, 0, 0, 0, 0,  37, 18, 0,  0);
        tbl[2]  = mk(1, 1, 1, 0, 0, 0, 0,  38, 18, 0,  0);
        tbl[3]  = mk(1, 1, 3, 0, 0, 0, 0,  39, 19, 0,  0);
        tbl[4]  = mk(1, 1, 3, 0, 0, 0, 0,  39, 19, 0,  0);
        tbl[5]  = mk(0, 1, 0, 0, 0, 0, 0,  39, 19, 0,  0);
        tbl[6]  = mk(1, 1, 0, 0, 0, 0, 0,  40, 19, 0,  0);
        tbl[7]  = mk(1, 1, 0, 0, 0, 0, 0,  40, 20, 0,  0);
        tbl[8]  = mk(1, 1, 0, 0, 1, 0, 0,  40, 20, 0,  0);
        tbl[9]  = mk(1, 1, 3, 0, 0, 0, 0,  39, 20, 1, 20);
        tbl[10] = mk(1, 1, 3, 0, 0, 0, 0,  39, 19, 1, 20);
        tbl[11] = mk(1, 1, 3, 0, 0, 0, 1,  39, 19, 0, 20);
        tbl[12] = mk(1, 1, 1, 0, 0, 0, 0,  38, 19, 0, 20);
        tbl[13] = mk(1, 1, 1, 0, 0, 0, 0,  38, 19, 0, 20);
        tbl[14] = mk(1, 1, 1, 0, 1, 0, 0,  38, 19, 0, 20);
        tbl[15] = mk(1, 1, 2, 0, 0, 0, 0,  37, 19, 1, 19);
        tbl[16] = mk(1, 1, 2, 0, 1, 0, 0,  37, 18, 1, 19);
        tbl[17] = mk(1, 1, 0, 0, 0, 0, 0,  36, 18, 1, 19);
        tbl[18] = mk(1, 1, 0, 0, 0, 0, 1,  36, 18, 1, 18);
        tbl[19] = mk(1, 1, 0, 0, 0, 0, 1,  36, 18, 0, 18);
        tbl[20] = mk(1, 1, 0, 0, 0, 0, 0,  36, 18, 0, 18);
        tbl[21] = mk(1, 1, 0, 1, 1, 0, 0,  36, 18, 0, 18);
        tbl[22] = mk(1, 1, 0, 0, 0, 0, 0,  36, 18, 1, 18);
        tbl[23] = mk(1, 1, 0, 0, 0, 0, 1,  36, 18, 0, 18);
        tbl[24] = mk(1, 1, 0, 0, 1, 0, 0,  36, 18, 0, 18);
        tbl[25] = mk(1, 1, 0, 0, 0, 1, 0,  36, 18, 0, 18);
        tbl[26] = mk(1, 1, 3, 0, 0, 0, 0,  35, 18, 0, 18);
        tbl[27] = mk(1, 1, 3, 0, 0, 0, 0,  35, 17, 0, 18);
        tbl[28] = mk(1, 0, 1, 0, 0, 0, 0,  35, 17, 0, 18);
        tbl[29] = mk(1, 0, 2, 0, 0, 0, 0,  35, 17, 0, 18);
        tbl[30] = mk(1, 0, 0, 0, 0, 0, 0,  35, 17, 0, 18);
        tbl[31] = mk(1, 0, 0, 1, 0, 0, 0,  35, 17, 0, 18);
        tbl[32] = mk(1, 0, 0, 0, 0, 0, 0,  35, 17, 0, 18);

        // Reset state, during and just after reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst ht",     32'(bus.half_track), 36);
        chk("rst trk",    32'(bus.track), 18);
        chk("rst req",    32'(bus.save_req), 0);
        chk("rst strk",   32'(bus.save_track), 0);
        chk("rst settle", 32'(bus.settling), 0);
        chk("rst tr00n",  32'(bus.tr00_sense_n), 1);
        reset_n = 1'b1;
        #1;
        chk("rel ht",     32'(bus.half_track), 36);
        chk("rel trk",    32'(bus.track), 18);

        for (int i = 0; i < NVEC; i++) begin
            bus.ce = tbl[i].ce; bus.mtr = tbl[i].mtr; bus.stp = tbl[i].stp;
            bus.act = tbl[i].act; bus.buff_we = tbl[i].we;
            bus.disk_change = tbl[i].dc; bus.save_ack = tbl[i].ack;
            tick();
            chk($sformatf("row%0d ht", i),   32'(bus.half_track), 32'(tbl[i].ht));
            chk($sformatf("row%0d trk", i),  32'(bus.track),      32'(tbl[i].trk));
            chk($sformatf("row%0d req", i),  32'(bus.save_req),   32'(tbl[i].req));
            chk($sformatf("row%0d strk", i), 32'(bus.save_track), 32'(tbl[i].strk));
            if (i == 1)
                chk("row1 settling", 32'(bus.settling), 1);
        end
        cur_ph = 2'd0;

        // Step and act fall on the same tick form a single save event
        idle_inputs(); bus.mtr = 1'b1; bus.act = 1'b1;
        tick();
        bus.buff_we = 1'b1;
        tick();
        bus.buff_we = 1'b0; bus.act = 1'b0; cur_ph = fwd_ph(cur_ph); bus.stp = cur_ph;
        tick();
        chk("stpact ht",   32'(bus.half_track), 36);
        chk("stpact req",  32'(bus.save_req), 1);
        chk("stpact strk", 32'(bus.save_track), 17);
        bus.save_ack = 1'b1;
        tick();
        chk("stpact ack req", 32'(bus.save_req), 0);
        bus.save_ack = 1'b0;
        tick();
        chk("stpact no pend", 32'(bus.save_req), 0);

        // Reverse clamp at MIN_HT
        for (int i = 0; i < 40; i++) begin
            cur_ph = rev_ph(cur_ph); bus.stp = cur_ph;
            tick();
        end
        chk("clamp lo ht", 32'(bus.half_track), 1);
        tick();
        chk("clamp lo trk",   32'(bus.track), 0);
        chk("clamp lo tr00n", 32'(bus.tr00_sense_n), 0);
        chk("clamp lo req",   32'(bus.save_req), 0);

        // A clamped step is still a save event
        bus.buff_we = 1'b1;
        tick();
        bus.buff_we = 1'b0; cur_ph = rev_ph(cur_ph); bus.stp = cur_ph;
        tick();
        chk("clamp ev ht",   32'(bus.half_track), 1);
        chk("clamp ev req",  32'(bus.save_req), 1);
        chk("clamp ev strk", 32'(bus.save_track), 0);
        bus.save_ack = 1'b1;
        tick();
        bus.save_ack = 1'b0;
        chk("clamp ev ack", 32'(bus.save_req), 0);

        // Forward clamp at MAX_HT
        for (int i = 0; i < 90; i++) begin
            cur_ph = fwd_ph(cur_ph); bus.stp = cur_ph;
            tick();
        end
        chk("clamp hi ht", 32'(bus.half_track), 80);
        tick();
        chk("clamp hi trk",   32'(bus.track), 40);
        chk("clamp hi tr00n", 32'(bus.tr00_sense_n), 1);

        // Settle window is SETTLE ticks from the last position change
        cur_ph = rev_ph(cur_ph); bus.stp = cur_ph;
        tick();
        chk("settle start ht", 32'(bus.half_track), 79);
        chk("settle start",    32'(bus.settling), 1);
        repeat (2999) tick();
        chk("settle last", 32'(bus.settling), 1);
        tick();
        chk("settle done", 32'(bus.settling), 0);

        // Held request stays stable without ack, then reset drops it
        bus.buff_we = 1'b1;
        tick();
        bus.buff_we = 1'b0; cur_ph = fwd_ph(cur_ph); bus.stp = cur_ph;
        tick();
        chk("hold ht", 32'(bus.half_track), 80);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("hold%0d req", i),  32'(bus.save_req), 1);
            chk($sformatf("hold%0d strk", i), 32'(bus.save_track), 39);
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst req",    32'(bus.save_req), 0);
        chk("midrst strk",   32'(bus.save_track), 0);
        chk("midrst ht",     32'(bus.half_track), 36);
        chk("midrst trk",    32'(bus.track), 18);
        chk("midrst settle", 32'(bus.settling), 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/c1541_head_stepper.md
# c1541_head_stepper

Head-position and track-save controller for the 1541 drive model. It decodes the two stepper-phase outputs of `c1541_logic` into a clamped half-track position and presents the whole-track number to the GCR encoder and the SD track buffer. It also tracks whether the buffered track was written, and issues a req/ack save request to the track buffer whenever the head leaves a dirty track or drive activity stops. It sits between `c1541_logic` (upstream: `stp`, `mtr`, `act`) and `c1541_gcr`/`c1541_track` (downstream: `track`, save request).

## Interface
- `START_HT`, 36: half-track position after reset (track 18).
- `MIN_HT`, 1: lowest reachable half-track.
- `MAX_HT`, 80: highest reachable half-track.
- `SETTLE`, 3000: `ce` ticks that `settling` stays high after a position change (1..65535).

Ports:
- `clk` in 1: drive clock, same clock as the rest of the drive.
- `reset_n` in 1: asynchronous, active-low reset.
- `ce` in 1: clock enable. All state advances only on `clk` edges with `ce=1`.
- `mtr` in 1: spindle motor on. Steps are decoded only while high.
- `stp` in 2: stepper phase from the VIA.
- `act` in 1: drive activity LED signal.
- `buff_we` in 1: track buffer write strobe, which marks the track dirty.
- `disk_change` in 1: level. While high, the dirty flag is cleared.
- `save_ack` in 1: track buffer accepted the save; sampled on `ce`.
- `half_track` out 7: current head position, MIN_HT..MAX_HT.
- `track` out 6: `half_track[6:1]`, registered.
- `tr00_sense_n` out 1: 0 when `track==0`, else 1.
- `settling` out 1: head still moving; the GCR stage may hold off.
- `save_req` out 1: save request, held until acknowledged.
- `save_track` out 6: track to be written back; stable while `save_req=1`.

## Operation
- **Phase register.** `stp_r` captures `stp` on every `ce`, independent of `mtr`.
- **Forward step.** Transitions (stp_r→stp) 0→2, 2→1, 1→3, 3→0.
- **Reverse step.** Transitions 0→3, 3→1, 1→2, 2→0.
- **Ignored transitions.** Equal phases and diagonal jumps (0↔1, 2↔3) are ignored.
- **Step acceptance.** A step is accepted only if `mtr=1`.
  - Forward: `half_track+1` if `half_track<MAX_HT`, else unchanged.
  - Reverse: `half_track-1` if `half_track>MIN_HT`, else unchanged.
  - A clamped step is still an accepted step and counts as a save event.
- **Track output.** `track` is updated from `half_track` on every `ce`, so it lags `half_track` by one `ce` tick.
- **Dirty flag.**
  - Set by `buff_we` on a `ce` tick.
  - Cleared while `disk_change=1`.
  - Cleared when a save event fires. A save event overrides a same-tick `buff_we`, because that write belongs to the track being saved.
- **Save event.** Either an accepted step or a falling edge of `act` (previous `ce` value 1, current 0).
- **Save request state machine** (IDLE, REQ):
  - IDLE: a save event with dirty=1 sets `save_req=1` and latches `save_track=track` (the old track, pre-update), then goes to REQ. A save event with dirty=0 does nothing.
  - REQ: hold `save_req` and `save_track`. A new dirty save event in REQ sets a one-deep `pend` flag and latches `pend_track`; further events overwrite `pend_track`.
  - REQ with `save_ack=1`: if `pend` is set, load `save_track=pend_track`, clear `pend`, and keep `save_req=1` with the new track. Otherwise drop `save_req` and return to IDLE.
  - `disk_change=1` clears `pend` but does not cancel an outstanding `save_req`.
- **Settle counter** (16 bits).
  - Loaded with SETTLE whenever `half_track` actually changes, restarting if already running.
  - Decrements on each `ce` while nonzero.
  - `settling = (cnt != 0)`.

## Timing
- **Reset values** (`reset_n=0`, asynchronous):
  - `half_track=START_HT`, `track=START_HT>>1` (18), `tr00_sense_n=1`.
  - `settling=0`, `save_req=0`, `save_track=0`.
  - dirty=0, `pend=0`, `stp_r=0`, previous `act`=0.
- **Reset mid-save.** Asserting reset during a save drops `save_req` with no acknowledge needed.
- **Latencies:**
  - Phase change to `half_track`: 1 `ce` tick.
  - Phase change to `track`: 2 `ce` ticks.
  - Save event to `save_req`: 1 `ce` tick.
  - `save_ack` to `save_req` low: 1 `ce` tick.
- **`ce=0`.** All outputs hold.
- **Step and `act` fall on the same tick.** Treated as a single save event.

## Test plan
- **Reset state.** Reset, then release → `half_track=36`, `track=18`, `save_req=0`, `settling=0`, `tr00_sense_n=1`.
- **Forward stepping.** `mtr=1`, phases 0,2,1,3 (one per `ce`) → `half_track` 37,38,39. `track` reads 19 two ticks after the second step. `settling=1` for 3000 ticks after the last step.
- **Dirty save on step.** Pulse `buff_we`, then a reverse step 0→3 → `save_req=1` with `save_track=18`. Hold `save_ack` low for 10 ticks: request stays stable. Ack → `save_req=0` next tick. A further step with no write → no request.
- **Clamping.** Drive 40 reverse steps from 36 → stop at 1, `track=0`, `tr00_sense_n=0`. `mtr=0` with phase toggling → no movement.
- **Pending save.** Save outstanding, then another write plus a step → on ack, `save_req` stays high with `save_track` equal to the new old-track. Second ack → `save_req=0`.
- **Activity fall and disk change.** Write, then `act` 1→0 → request issued. Separately: write, assert `disk_change`, then step → no request.
